// File: rtl/mci_ecc_pkg.sv
// mci_ecc_pkg: shared types and default constants for the MCU SRAM ECC
// error tracker and its error-log FIFO.
//
// Optional feature macro: MCI_ECC_LOG_TIMESTAMP_EN adds a 32-bit timestamp
// field to every log entry.
package mci_ecc_pkg;

  localparam int MCI_ECC_ADDR_W    = 18;
  localparam int MCI_ECC_CNT_W     = 16;
  localparam int MCI_ECC_LOG_DEPTH = 4;
  localparam int MCI_ECC_TS_W      = 32;

  typedef enum logic {
    ECC_SB = 1'b0,
    ECC_DB = 1'b1
  } ecc_err_type_e;

  // Layout of one log entry for the default address width. The top packs
  // entries in this same field order: type in the MSB, timestamp in the LSBs.
  typedef struct packed {
    ecc_err_type_e               err_type;
    logic [MCI_ECC_ADDR_W-1:0]   addr;
`ifdef MCI_ECC_LOG_TIMESTAMP_EN
    logic [MCI_ECC_TS_W-1:0]     ts;
`endif
  } ecc_log_entry_t;

endpackage

// File: rtl/mci_ecc_err_log_fifo.sv
// mci_ecc_err_log_fifo: synchronous error-log FIFO.
//
// Ports:
//   clk, rst_b      clock, asynchronous active-low reset
//   push, push_data write request and entry; dropped when full with no pop
//   pop_ready       consumer pop; ignored while empty
//   clr_overflow    clears the sticky overflow flag
//   valid           FIFO non-empty (registered)
//   head_data       head entry (registered, stable until popped)
//   overflow        sticky: an entry was dropped
//
// Pointers carry one extra wrap bit so full/empty decode from the MSB and the
// lower-bit compare. The head entry is registered: its next value is computed
// from the post-update read pointer, bypassing push_data when the new entry
// lands directly in the head slot.
module mci_ecc_err_log_fifo #(
  parameter int DATA_W = 19,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_ready,
  input  logic              clr_overflow,
  output logic              valid,
  output logic [DATA_W-1:0] head_data,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic              full, empty, do_pop, do_push, drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = !empty && pop_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign wr_ptr_n = do_push ? wr_ptr + PTR_ONE : wr_ptr;
  assign rd_ptr_n = do_pop  ? rd_ptr + PTR_ONE : rd_ptr;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      valid     <= 1'b0;
      head_data <= '0;
      overflow  <= 1'b0;
    end else begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      valid    <= (wr_ptr_n != rd_ptr_n);
      if (do_push && (wr_ptr == rd_ptr_n)) head_data <= push_data;
      else                                 head_data <= mem[rd_ptr_n[AW-1:0]];
      overflow <= drop | (overflow & ~clr_overflow);
    end
  end

endmodule

// File: rtl/mci_mcu_sram_ecc_err_tracker.sv
// mci_mcu_sram_ecc_err_tracker: tracks ECC error pulses from the MCU SRAM
// controller.
//
// Ports:
//   clk, rst_b                    clock, asynchronous active-low reset
//   sram_single/double_ecc_error  per-read error pulses; double dominates
//   sram_err_addr                 failing word address
//   sb_thresh                     single-bit interrupt threshold (0 = off)
//   clr_sb_cnt, clr_db_cnt        counter clear pulses
//   clr_status                    clears sticky bits and log_overflow
//   sb_cnt, db_cnt                saturating error counters
//   sb_sticky, db_sticky          sticky error flags
//   first_db_addr                 address of first double error since clear
//   sb_thresh_intr, db_intr       one-cycle interrupt pulses
//   log_valid/log_ready           error-log pop handshake
//   log_type, log_addr            head log entry
//   log_overflow                  sticky log drop flag
//   log_ts                        head entry timestamp (MCI_ECC_LOG_TIMESTAMP_EN only)
//
// Optional feature macro: MCI_ECC_LOG_TIMESTAMP_EN.
module mci_mcu_sram_ecc_err_tracker
  import mci_ecc_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter int CNT_WIDTH  = MCI_ECC_CNT_W,
  parameter int LOG_DEPTH  = MCI_ECC_LOG_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  sram_single_ecc_error,
  input  logic                  sram_double_ecc_error,
  input  logic [ADDR_WIDTH-1:0] sram_err_addr,
  input  logic [CNT_WIDTH-1:0]  sb_thresh,
  input  logic                  clr_sb_cnt,
  input  logic                  clr_db_cnt,
  input  logic                  clr_status,
  output logic [CNT_WIDTH-1:0]  sb_cnt,
  output logic [CNT_WIDTH-1:0]  db_cnt,
  output logic                  sb_sticky,
  output logic                  db_sticky,
  output logic [ADDR_WIDTH-1:0] first_db_addr,
  output logic                  sb_thresh_intr,
  output logic                  db_intr,
  output logic                  log_valid,
  input  logic                  log_ready,
  output logic                  log_type,
  output logic [ADDR_WIDTH-1:0] log_addr,
  output logic                  log_overflow
`ifdef MCI_ECC_LOG_TIMESTAMP_EN
  ,
  output logic [MCI_ECC_TS_W-1:0] log_ts
`endif
);

`ifdef MCI_ECC_LOG_TIMESTAMP_EN
  localparam int ENTRY_W = 1 + ADDR_WIDTH + MCI_ECC_TS_W;
`else
  localparam int ENTRY_W = 1 + ADDR_WIDTH;
`endif
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  endfunction

  // A clear coincident with an event restarts the count at 1 so the event
  // is not lost.
  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic clr, input logic ev);
    logic [CNT_WIDTH-1:0] r;
    if (clr)     r = ev ? CNT_ONE : '0;
    else if (ev) r = sat_inc(cnt);
    else         r = cnt;
    return r;
  endfunction

  logic                  ev_sb, ev_db, sb_fire;
  ecc_err_type_e         ev_type;
  logic [CNT_WIDTH-1:0]  sb_cnt_n, db_cnt_n;
  logic [ENTRY_W-1:0]    push_data, head_data;

  // Stage 0: event decode and next-state computation
  assign ev_db    = sram_double_ecc_error;
  assign ev_sb    = sram_single_ecc_error & ~sram_double_ecc_error;
  assign ev_type  = ev_db ? ECC_DB : ECC_SB;
  assign sb_cnt_n = cnt_next(sb_cnt, clr_sb_cnt, ev_sb);
  assign db_cnt_n = cnt_next(db_cnt, clr_db_cnt, ev_db);
  // An event on an already saturated counter does not count as reaching
  // the threshold again.
  assign sb_fire  = ev_sb && (sb_thresh != '0) && (sb_cnt_n == sb_thresh) &&
                    !(!clr_sb_cnt && (sb_cnt == CNT_MAX));

  // Stage 1: registered outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sb_cnt         <= '0;
      db_cnt         <= '0;
      sb_sticky      <= 1'b0;
      db_sticky      <= 1'b0;
      first_db_addr  <= '0;
      sb_thresh_intr <= 1'b0;
      db_intr        <= 1'b0;
    end else begin
      sb_cnt         <= sb_cnt_n;
      db_cnt         <= db_cnt_n;
      sb_sticky      <= ev_sb | (sb_sticky & ~clr_status);
      db_sticky      <= ev_db | (db_sticky & ~clr_status);
      if (ev_db && (!db_sticky || clr_status)) first_db_addr <= sram_err_addr;
      sb_thresh_intr <= sb_fire;
      db_intr        <= ev_db;
    end
  end

`ifdef MCI_ECC_LOG_TIMESTAMP_EN
  logic [MCI_ECC_TS_W-1:0] ts_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 32'd1;
  end

  assign push_data = {ev_type, sram_err_addr, ts_cnt};
  assign {log_type, log_addr, log_ts} = head_data;
`else
  assign push_data = {ev_type, sram_err_addr};
  assign {log_type, log_addr} = head_data;
`endif

  mci_ecc_err_log_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (LOG_DEPTH)
  ) u_log_fifo (
    .clk          (clk),
    .rst_b        (rst_b),
    .push         (ev_sb | ev_db),
    .push_data    (push_data),
    .pop_ready    (log_ready),
    .clr_overflow (clr_status),
    .valid        (log_valid),
    .head_data    (head_data),
    .overflow     (log_overflow)
  );

endmodule

// File: doc/mci_mcu_sram_ecc_err_tracker.md
Name: mci_mcu_sram_ecc_err_tracker

Overview:
- Sits directly downstream of the MCU SRAM controller inside MCI.
- Consumes the controller's per-access single-bit and double-bit ECC error pulses and the failing word address.
- Maintains saturating error counters and sticky status, and raises threshold/fatal interrupt pulses.
- Buffers failing addresses in a small error-log FIFO that firmware or the register block drains through a valid/ready handshake.

Parameters:
ADDR_WIDTH, 18, SRAM word-address width (1024 KB / 4 B words).
CNT_WIDTH, 16, width of each error counter.
LOG_DEPTH, 4, error-log FIFO entries; must be a power of two and at least 2.

Ports:
clk  input  1  MCI clock.
rst_b  input  1  asynchronous active-low reset.
sram_single_ecc_error  input  1  one-cycle pulse: corrected error on the current read.
sram_double_ecc_error  input  1  one-cycle pulse: uncorrectable error on the current read.
sram_err_addr  input  ADDR_WIDTH  word address of the failing read; valid when either error pulse is high.
sb_thresh  input  CNT_WIDTH  single-bit interrupt threshold; 0 disables the interrupt.
clr_sb_cnt  input  1  pulse: zero sb_cnt.
clr_db_cnt  input  1  pulse: zero db_cnt.
clr_status  input  1  pulse: clear sb_sticky, db_sticky, log_overflow.
sb_cnt  output  CNT_WIDTH  single-bit error count, saturating.
db_cnt  output  CNT_WIDTH  double-bit error count, saturating.
sb_sticky  output  1  a single-bit error has occurred since the last clear.
db_sticky  output  1  a double-bit error has occurred since the last clear.
first_db_addr  output  ADDR_WIDTH  address of the first double-bit error since db_sticky was last cleared.
sb_thresh_intr  output  1  one-cycle pulse when sb_cnt reaches sb_thresh.
db_intr  output  1  one-cycle pulse for each double-bit error.
log_valid  output  1  error-log FIFO is non-empty.
log_ready  input  1  consumer pop.
log_type  output  1  head entry type: 0 = single-bit, 1 = double-bit.
log_addr  output  ADDR_WIDTH  head entry address.
log_overflow  output  1  sticky: an entry was dropped because the FIFO was full.

Behaviour:
- Reset: all outputs and all internal state are 0. Assertion is asynchronous; deassertion is sampled on clk. Reset mid-operation discards all FIFO contents and counts.
- Event decode: ev_db = sram_double_ecc_error; ev_sb = sram_single_ecc_error AND NOT sram_double_ecc_error. Double dominates, so a simultaneous pulse counts as one double-bit event only.
- Latency: an event at cycle N is visible in the counters, sticky bits, interrupts and log_valid at cycle N+1. All outputs are registered.
- Counters: increment by 1 per event and saturate at all-ones. A clear together with an event in the same cycle gives a result of 1, so the event is not lost. A clear alone gives 0.
- sb_thresh_intr pulses for one cycle when the post-increment sb_cnt equals sb_thresh and sb_thresh != 0. It does not re-fire while the counter is saturated, and it does not fire on a threshold change alone.
- Sticky bits: set on their event. clr_status with a simultaneous event leaves the bit set.
- first_db_addr is captured only when db_sticky is 0, or when clr_status and ev_db occur in the same cycle.
- db_intr pulses for one cycle per ev_db, including back-to-back events.
- Log FIFO push: on any event, push {type, sram_err_addr}.
- Log FIFO pop: occurs when log_valid && log_ready.
- Log FIFO full:
  - Push without pop: entry dropped, log_overflow set.
  - Push with pop in the same cycle: both succeed, occupancy unchanged, no overflow.
- Log FIFO empty: log_valid = 0; log_ready is ignored. A push into the empty FIFO appears at the head at N+1. There is no fall-through.
- Pointers are log2(LOG_DEPTH)+1 bits and wrap modulo 2*LOG_DEPTH. Full and empty are decoded from the MSB and the lower-bit compare.
- log_type/log_addr are held stable while log_valid=1 and no pop occurs.

Optional Feature:
- Macro: MCI_ECC_LOG_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter is added; it resets to 0 and wraps.
  - Each log entry also stores the counter value at the push cycle.
  - Extra output log_ts [31:0] presents the head entry's stored timestamp.
- Undefined: no counter and no log_ts port. FIFO entry width is 1+ADDR_WIDTH.

Decomposition:
- Package mci_ecc_pkg:
  - enum ecc_err_type_e {ECC_SB=1'b0, ECC_DB=1'b1}.
  - struct ecc_log_entry_t {type, addr[, ts]}.
  - Default constants MCI_ECC_CNT_W=16, MCI_ECC_LOG_DEPTH=4.
- Sub-module mci_ecc_err_log_fifo:
  - Parameterized sync FIFO with push/full-drop/overflow/valid-ready pop.
  - The top holds counters, sticky bits and interrupts.

Test Plan:
- 3 single pulses, addr 0x10/0x11/0x12, sb_thresh=3 -> sb_cnt=3; sb_thresh_intr one pulse in the cycle after the 3rd; log pops give type 0 at 0x10, 0x11, 0x12 in order.
- Single+double in the same cycle at addr 0x2A -> db_cnt=1, sb_cnt=0, db_intr one pulse, first_db_addr=0x2A, one log entry of type 1.
- 5 events with log_ready=0, LOG_DEPTH=4 -> 4 entries held; log_overflow=1 after the 5th; the 5th address is absent. Push+pop while full -> no further overflow, occupancy stays 4.
- Force sb_cnt to 0xFFFE, then 3 single events -> sb_cnt sticks at 0xFFFF; no repeated sb_thresh_intr with sb_thresh=0xFFFF.
- clr_sb_cnt and a single event in the same cycle with sb_cnt=7 -> sb_cnt=1. clr_status together with a double at 0x3 -> db_sticky=1, first_db_addr=0x3.
- Assert rst_b mid-stream with 2 log entries -> log_valid=0, all counters 0 immediately without waiting for a clock edge. Subsequent operation is normal.
